// File: rtl/int_pipe_if.sv
// Pipeline <-> interrupt sequencer signal bundle.
// master = sequencer side, slave = pipeline side.
interface int_pipe_if #(
  parameter int N_IRQ = 3
);
  localparam int CW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic          id_stall;
  logic          ex_flush;
  logic          halt;
  logic          mem_int_enter;
  logic          mem_uret;
  logic          int_issue;
  logic [CW-1:0] int_cause;
  logic          busy;

  modport master (
    input  id_stall,
    input  ex_flush,
    input  halt,
    input  mem_int_enter,
    input  mem_uret,
    output int_issue,
    output int_cause,
    output busy
  );

  modport slave (
    output id_stall,
    output ex_flush,
    output halt,
    output mem_int_enter,
    output mem_uret,
    input  int_issue,
    input  int_cause,
    input  busy
  );
endinterface

// File: rtl/int_pipe_ctrl.sv
// Interrupt sequencer: sync/edge-detect requests, pick a
// preempting source, track the Int_Enter bubble to commit.
module int_pipe_ctrl #(
  parameter int N_IRQ       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic             ie,
  output logic [N_IRQ-1:0] irs,
  output logic [N_IRQ-1:0] pending,
  int_pipe_if.master       pif
);
  localparam int CW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] prev_q, rise;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] irs_q, irs_d;
  logic [N_IRQ-1:0] clr, restore_m, uret_m;
  logic [CW-1:0]    cause_q, cause_d, cand;
  logic             cand_ok, issue_ok;
  logic             issue_q, first_q;
  logic             restore, commit;

  // Request synchroniser chain plus edge-detect flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= irq;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Highest pending source strictly above the top in-service level
  always_comb begin
    cand_ok = 1'b0;
    cand    = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (pend_q[i] && ((irs_q >> i) == '0)) begin
        cand_ok = 1'b1;
        cand    = CW'(i);
      end
    end
  end

  // One-hot mask of the top in-service level, cleared by uret
  always_comb begin
    uret_m = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (irs_q[i]) begin
        uret_m    = '0;
        uret_m[i] = 1'b1;
      end
    end
  end

  assign issue_ok = ie & ~pif.halt & ~pif.id_stall
                  & ~pif.ex_flush & cand_ok;

  // Sequencer next state; flush only kills the bubble
  // in the first cycle after ISSUE
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    clr     = '0;
    restore = 1'b0;
    commit  = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (issue_ok) begin
          state_d   = S_ISSUE;
          cause_d   = cand;
          clr[cand] = 1'b1;
        end
      end
      (state_q == S_ISSUE): begin
        state_d = S_WAIT;
      end
      (state_q == S_WAIT): begin
        if (pif.mem_int_enter) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end else if (pif.ex_flush && first_q) begin
          restore = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pending and in-service next values
  always_comb begin
    restore_m = '0;
    if (restore)
      restore_m[cause_q] = 1'b1;
    pend_d = (pend_q & ~clr) | rise | restore_m;
    irs_d  = irs_q;
    if (pif.mem_uret)
      irs_d = irs_q & ~uret_m;
    if (commit)
      irs_d[cause_q] = 1'b1;
  end

  // Sequencer and vector registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cause_q <= '0;
      pend_q  <= '0;
      irs_q   <= '0;
      issue_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pend_q  <= pend_d;
      irs_q   <= irs_d;
      issue_q <= (state_d == S_ISSUE);
      first_q <= (state_q == S_ISSUE);
    end
  end

  assign pif.int_issue = issue_q;
  assign pif.int_cause = cause_q;
  assign pif.busy      = (state_q != S_IDLE);
  assign irs           = irs_q;
  assign pending       = pend_q;
endmodule
